dmem_arbiter: RTL

Shares the single data-memory port between the pipeline MEM stage and an external loader/debug port. It fixes the MEM_LAT access latency, stalls the pipeline while a CPU access is pending, and guarantees the external port forward progress with a bounded-wait starvation counter. It sits between the EX/MEM pipeline register outputs and `dataMemory`. The external port lets programs and data be loaded into, or read from, memory while the core runs.

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the pipeline MEM
// stage (CPU) and an external loader/debug port. Every transfer takes
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP. A starvation counter bounds how
// many CPU grants may pass while the external port is waiting.
//
// Ports
//   systemClock, reset         : clock, asynchronous active-high reset
//   cpu_memRead/cpu_memWrite   : pipeline load/store request (both high = write)
//   cpu_addr/cpu_wdata         : pipeline address / store data
//   cpu_rdata, cpu_stall       : CPU load data, pipeline freeze
//   ext_req/ext_we/ext_addr/ext_wdata : external transfer request
//   ext_rdata, ext_ack         : external read data, one-cycle completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata : dataMemory port
//   grant_ext                  : current or last owner (0 = CPU, 1 = external)
module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              systemClock,
   input  logic              reset,
   input  logic              cpu_memRead,
   input  logic              cpu_memWrite,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_ack,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              grant_ext
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              grant_ext_q, grant_ext_d;
   logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

   logic cpu_req;
   logic ext_win;
   logic lat_last;

   assign cpu_req  = cpu_memRead | cpu_memWrite;
   // External wins when the CPU is idle or the CPU has used up its wait budget.
   assign ext_win  = ext_req & (~cpu_req | (wait_cnt_q == WAIT_MAX));
   assign lat_last = (lat_cnt_q == LAT_LAST);

   // State register
   always_ff @(posedge systemClock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (cpu_req | ext_req) state_d = S_ACCESS;
         S_ACCESS: if (lat_last) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath next values: grant latch, latency/starvation counters, read capture
   always_comb begin
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      grant_ext_d = grant_ext_q;
      lat_cnt_d   = lat_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      cpu_rdata_d = cpu_rdata_q;
      ext_rdata_d = ext_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_req | ext_req) begin
               grant_ext_d = ext_win;
               lat_cnt_d   = '0;
               if (ext_win) begin
                  addr_d     = ext_addr;
                  wdata_d    = ext_wdata;
                  we_d       = ext_we;
                  wait_cnt_d = '0;
               end else begin
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
                  we_d    = cpu_memWrite;
                  // Count CPU grants only while the external port is waiting.
                  if (!ext_req) begin
                     wait_cnt_d = '0;
                  end else if (wait_cnt_q != WAIT_MAX) begin
                     wait_cnt_d = wait_cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         S_ACCESS: begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
            if (lat_last && !we_q) begin
               if (grant_ext_q) ext_rdata_d = mem_rdata;
               else             cpu_rdata_d = mem_rdata;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge systemClock or posedge reset) begin
      if (reset) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         grant_ext_q <= 1'b0;
         lat_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         cpu_rdata_q <= '0;
         ext_rdata_q <= '0;
      end else begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         grant_ext_q <= grant_ext_d;
         lat_cnt_q   <= lat_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         cpu_rdata_q <= cpu_rdata_d;
         ext_rdata_q <= ext_rdata_d;
      end
   end

   // Outputs decoded from registered state; stall must react to the live request.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ext_ack   = 1'b0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      grant_ext = grant_ext_q;
      cpu_rdata = cpu_rdata_q;
      ext_rdata = ext_rdata_q;
      if (state_q == S_ACCESS) begin
         mem_write = we_q;
         mem_read  = ~we_q;
      end
      if (state_q == S_RESP) ext_ack = grant_ext_q;
      cpu_stall = cpu_req & ~((state_q == S_RESP) & ~grant_ext_q);
   end

endmodule
